// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
// Programs BAUD/CTRL after reset, then polls STATUS and writes each granted byte to TXDATA.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter logic [31:0] BAUD_DIV       = 32'h1B8,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic                   busy_o,
    output logic                   timeout_o,
    output logic                   uart_we_o,
    output logic [31:0]            uart_addr_o,
    output logic [31:0]            uart_wdata_o,
    input  logic [31:0]            uart_rdata_i
);

    localparam int unsigned    GW        = $clog2(NUM_REQ);
    localparam logic [15:0]    POLL_LAST = TIMEOUT_CYCLES - 16'd1;
    localparam logic [GW-1:0]  LAST_INIT = GW'(NUM_REQ - 1);

    localparam logic [31:0] ADDR_CTRL   = 32'h00;
    localparam logic [31:0] ADDR_STATUS = 32'h04;
    localparam logic [31:0] ADDR_BAUD   = 32'h08;
    localparam logic [31:0] ADDR_TXDATA = 32'h0C;

    typedef enum logic [2:0] {
        S_INIT_BAUD,
        S_INIT_CTRL,
        S_IDLE,
        S_POLL,
        S_WRITE,
        S_ACK,
        S_DROP
    } state_t;

    state_t          state, state_next;
    logic            rst_hold;
    logic [GW-1:0]   last_grant, grant, sel;
    logic            sel_vld;
    logic [7:0]      sel_byte, tx_byte;
    logic [15:0]     poll_cnt;
    logic            unused_rdata;

    assign unused_rdata = ^uart_rdata_i[31:1];

    // First requester at or after last_grant+1, wrapping modulo NUM_REQ.
    always_comb begin : rr_pick
        int unsigned idx;
        idx      = 0;
        sel      = '0;
        sel_vld  = 1'b0;
        sel_byte = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(last_grant) + 1 + i) % NUM_REQ;
            if (!sel_vld && req_i[GW'(idx)]) begin
                sel      = GW'(idx);
                sel_vld  = 1'b1;
                sel_byte = req_data_i[8*idx +: 8];
            end
        end
    end

    // rst_hold keeps the bus quiet during the cycle(s) the reset is being sampled,
    // so the BAUD write appears only once reset has been released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_INIT_BAUD;
            rst_hold <= 1'b1;
        end else begin
            state    <= state_next;
            rst_hold <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= LAST_INIT;
            grant      <= '0;
            tx_byte    <= '0;
            poll_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_vld) begin
                        grant    <= sel;
                        tx_byte  <= sel_byte;
                        poll_cnt <= '0;
                    end
                end
                S_POLL: begin
                    if (uart_rdata_i[0] && poll_cnt != POLL_LAST) begin
                        poll_cnt <= poll_cnt + 16'd1;
                    end
                end
                S_ACK, S_DROP: last_grant <= grant;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        uart_we_o    = 1'b0;
        uart_addr_o  = '0;
        uart_wdata_o = '0;
        ack_o        = '0;
        timeout_o    = 1'b0;
        busy_o       = (state != S_IDLE);
        case (state)
            S_INIT_BAUD: begin
                if (!rst_hold) begin
                    uart_we_o    = 1'b1;
                    uart_addr_o  = ADDR_BAUD;
                    uart_wdata_o = BAUD_DIV;
                    state_next   = S_INIT_CTRL;
                end
            end
            S_INIT_CTRL: begin
                uart_we_o    = 1'b1;
                uart_addr_o  = ADDR_CTRL;
                uart_wdata_o = 32'h1;
                state_next   = S_IDLE;
            end
            S_IDLE: begin
                uart_addr_o = ADDR_STATUS;
                if (sel_vld) begin
                    state_next = S_POLL;
                end
            end
            S_POLL: begin
                uart_addr_o = ADDR_STATUS;
                if (!uart_rdata_i[0]) begin
                    state_next = S_WRITE;
                end else if (poll_cnt == POLL_LAST) begin
                    state_next = S_DROP;
                end
            end
            S_WRITE: begin
                uart_we_o    = 1'b1;
                uart_addr_o  = ADDR_TXDATA;
                uart_wdata_o = {24'h0, tx_byte};
                state_next   = S_ACK;
            end
            S_ACK: begin
                ack_o      = NUM_REQ'(1) << grant;
                state_next = S_IDLE;
            end
            S_DROP: begin
                ack_o      = NUM_REQ'(1) << grant;
                timeout_o  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_INIT_BAUD;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one task per scenario, with a small UART busy model
// driving STATUS and a second instance built with an 8-cycle poll timeout.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_t;
    logic [3:0]  req, req_t;
    logic [31:0] req_data, data_t;
    logic [3:0]  ack, ack_t;
    logic        busy, busy_t, tmo, tmo_t, we, we_t;
    logic [31:0] addr, wdata, rdata, addr_t, wdata_t, rdata_t;

    int nvec = 0;
    int nerr = 0;
    int busy_len = 0;
    int busy_cnt = 0;
    bit stuck = 1'b0;

    logic [31:0] wq[$];
    bit          pq[$];
    logic [3:0]  aq[$];
    bit          prev_ok = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(4), .BAUD_DIV(32'h1B8), .TIMEOUT_CYCLES(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .req_i(req), .req_data_i(req_data), .ack_o(ack),
        .busy_o(busy), .timeout_o(tmo), .uart_we_o(we), .uart_addr_o(addr),
        .uart_wdata_o(wdata), .uart_rdata_i(rdata)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .BAUD_DIV(32'h1B8), .TIMEOUT_CYCLES(16'd8)) dut_to (
        .clk(clk), .rst(rst_t), .req_i(req_t), .req_data_i(data_t), .ack_o(ack_t),
        .busy_o(busy_t), .timeout_o(tmo_t), .uart_we_o(we_t), .uart_addr_o(addr_t),
        .uart_wdata_o(wdata_t), .uart_rdata_i(rdata_t)
    );

    // UART model: busy for busy_len cycles after each TXDATA write; 'stuck' forces busy.
    always @(posedge clk) begin
        if (we && addr == 32'hC) busy_cnt <= busy_len;
        else if (busy_cnt > 0)   busy_cnt <= busy_cnt - 1;
    end
    assign rdata   = (addr == 32'h4) ? {31'b0, stuck || (busy_cnt != 0)} : 32'h0;
    assign rdata_t = (addr_t == 32'h4) ? 32'h1 : 32'h0;

    always @(negedge clk) begin
        if (we && addr == 32'hC) begin
            wq.push_back(wdata);
            pq.push_back(prev_ok);
        end
        if (ack != 4'b0) aq.push_back(ack);
        prev_ok = !we && addr == 32'h4 && rdata[0] == 1'b0;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_t = 1'b1; req = '0; req_t = '0; req_data = '0; data_t = '0;
        step();
        nvec++;
        if ({we, ack, tmo} !== 6'b0) begin
            nerr++; $display("FAIL reset_hold: got %b expected %b", {we, ack, tmo}, 6'b0);
        end
        rst = 1'b0;
        step();
        nvec++;
        if ({we, addr, wdata, busy} !== {1'b1, 32'h8, 32'h1B8, 1'b1}) begin
            nerr++; $display("FAIL init_baud: got %h expected %h", {we, addr, wdata, busy}, {1'b1, 32'h8, 32'h1B8, 1'b1});
        end
        step();
        nvec++;
        if ({we, addr, wdata, busy} !== {1'b1, 32'h0, 32'h1, 1'b1}) begin
            nerr++; $display("FAIL init_ctrl: got %h expected %h", {we, addr, wdata, busy}, {1'b1, 32'h0, 32'h1, 1'b1});
        end
        step();
        nvec++;
        if ({we, addr, busy, ack, tmo} !== {1'b0, 32'h4, 1'b0, 4'b0, 1'b0}) begin
            nerr++; $display("FAIL idle_after_init: got %h expected %h", {we, addr, busy, ack, tmo}, {1'b0, 32'h4, 1'b0, 4'b0, 1'b0});
        end
    endtask

    task automatic test_rotation();
        bit all_ok;
        wq.delete(); pq.delete(); aq.delete();
        busy_len = 20;
        req_data = 32'h13121110;
        req = 4'b1111;
        for (int c = 0; c < 400 && wq.size() < 5; c++) step();
        req = 4'b0;
        for (int c = 0; c < 100 && busy; c++) step();
        step();
        nvec++;
        if (wq.size() != 5 || {wq[0][7:0], wq[1][7:0], wq[2][7:0], wq[3][7:0], wq[4][7:0]} !== 40'h1011121310) begin
            nerr++; $display("FAIL rr_txdata_order: got %0d writes %h expected 5 writes %h", wq.size(),
                             {wq[0][7:0], wq[1][7:0], wq[2][7:0], wq[3][7:0], wq[4][7:0]}, 40'h1011121310);
        end
        nvec++;
        if (aq.size() != 5 || {aq[0], aq[1], aq[2], aq[3], aq[4]} !== 20'h12481) begin
            nerr++; $display("FAIL rr_ack_order: got %0d acks %h expected 5 acks %h", aq.size(),
                             {aq[0], aq[1], aq[2], aq[3], aq[4]}, 20'h12481);
        end
        all_ok = (pq.size() == 5);
        foreach (pq[i]) if (!pq[i]) all_ok = 1'b0;
        nvec++;
        if (!all_ok) begin
            nerr++; $display("FAIL rr_poll_before_write: got %b expected %b", all_ok, 1'b1);
        end
        for (int c = 0; c < 50 && busy_cnt != 0; c++) step();
    endtask

    task automatic test_single();
        busy_len = 0;
        wq.delete(); aq.delete();
        req_data = 32'h005A0000;
        req = 4'b0100;
        step();
        nvec++;
        if ({we, addr, busy} !== {1'b0, 32'h4, 1'b1}) begin
            nerr++; $display("FAIL single_poll: got %h expected %h", {we, addr, busy}, {1'b0, 32'h4, 1'b1});
        end
        step();
        nvec++;
        if ({we, addr, wdata} !== {1'b1, 32'hC, 32'h5A}) begin
            nerr++; $display("FAIL single_write: got %h expected %h", {we, addr, wdata}, {1'b1, 32'hC, 32'h5A});
        end
        step();
        nvec++;
        if ({ack, tmo, busy} !== {4'b0100, 1'b0, 1'b1}) begin
            nerr++; $display("FAIL single_ack: got %b expected %b", {ack, tmo, busy}, {4'b0100, 1'b0, 1'b1});
        end
        req = 4'b0;
        step();
        nvec++;
        if ({ack, busy, we} !== 6'b0) begin
            nerr++; $display("FAIL single_back_idle: got %b expected %b", {ack, busy, we}, 6'b0);
        end
        step(); step();
        nvec++;
        if (wq.size() != 1 || aq.size() != 1) begin
            nerr++; $display("FAIL single_write_count: got %0d writes %0d acks expected 1 and 1", wq.size(), aq.size());
        end
    endtask

    task automatic test_back_to_back();
        int nacks = 0;
        int last_c = 0;
        int idle = 0;
        busy_len = 0;
        wq.delete();
        req_data = 32'h30000000;
        req = 4'b1000;
        for (int c = 0; c < 200 && nacks < 5; c++) begin
            step();
            if (ack != 4'b0) begin
                nacks++;
                nvec++;
                if (ack !== 4'b1000) begin
                    nerr++; $display("FAIL b2b_ack_value: got %b expected %b", ack, 4'b1000);
                end
                if (nacks > 1) begin
                    nvec++;
                    if (c - last_c != 4) begin
                        nerr++; $display("FAIL b2b_spacing: got %0d expected %0d", c - last_c, 4);
                    end
                end
                last_c = c;
                if (nacks == 5) req = 4'b0;
                else req_data[31:24] = 8'h30 + 8'(nacks);
            end else if (nacks >= 1 && !busy) begin
                idle++;
            end
        end
        step(); step();
        nvec++;
        if (nacks != 5 || idle != 4) begin
            nerr++; $display("FAIL b2b_grants_idle: got %0d acks %0d idle expected 5 acks 4 idle", nacks, idle);
        end
        nvec++;
        if (wq.size() != 5 || {wq[0][7:0], wq[1][7:0], wq[2][7:0], wq[3][7:0], wq[4][7:0]} !== 40'h3031323334) begin
            nerr++; $display("FAIL b2b_txdata: got %0d writes %h expected 5 writes %h", wq.size(),
                             {wq[0][7:0], wq[1][7:0], wq[2][7:0], wq[3][7:0], wq[4][7:0]}, 40'h3031323334);
        end
    endtask

    task automatic test_rst_mid();
        stuck = 1'b0; busy_len = 0;
        req_data = 32'h00004100;
        req = 4'b0010;
        for (int c = 0; c < 20 && ack == 4'b0; c++) step();
        req = 4'b0;
        nvec++;
        if (ack !== 4'b0010) begin
            nerr++; $display("FAIL rstmid_setup_ack: got %b expected %b", ack, 4'b0010);
        end
        step();
        aq.delete();
        stuck = 1'b1;
        req_data = 32'h00420000;
        req = 4'b0100;
        step(); step();
        nvec++;
        if ({we, addr, busy} !== {1'b0, 32'h4, 1'b1}) begin
            nerr++; $display("FAIL rstmid_in_poll: got %h expected %h", {we, addr, busy}, {1'b0, 32'h4, 1'b1});
        end
        rst = 1'b1;
        step();
        nvec++;
        if ({we, ack, tmo} !== 6'b0) begin
            nerr++; $display("FAIL rstmid_first_cycle: got %b expected %b", {we, ack, tmo}, 6'b0);
        end
        rst = 1'b0; stuck = 1'b0;
        req_data = 32'hA30000A0;
        req = 4'b1001;
        step();
        nvec++;
        if ({we, addr, wdata} !== {1'b1, 32'h8, 32'h1B8}) begin
            nerr++; $display("FAIL rstmid_baud: got %h expected %h", {we, addr, wdata}, {1'b1, 32'h8, 32'h1B8});
        end
        step();
        nvec++;
        if ({we, addr, wdata} !== {1'b1, 32'h0, 32'h1}) begin
            nerr++; $display("FAIL rstmid_ctrl: got %h expected %h", {we, addr, wdata}, {1'b1, 32'h0, 32'h1});
        end
        step(); step(); step();
        nvec++;
        if ({we, addr, wdata} !== {1'b1, 32'hC, 32'hA0}) begin
            nerr++; $display("FAIL rstmid_req0_first: got %h expected %h", {we, addr, wdata}, {1'b1, 32'hC, 32'hA0});
        end
        step();
        req = 4'b0;
        step(); step();
        nvec++;
        if (aq.size() != 1 || aq[0] !== 4'b0001) begin
            nerr++; $display("FAIL rstmid_acks: got %0d acks first %b expected 1 ack %b", aq.size(), aq[0], 4'b0001);
        end
    endtask

    task automatic test_timeout();
        int polls = 0;
        int writes = 0;
        bit got = 1'b0;
        rst_t = 1'b0;
        step(); step(); step();
        data_t = 32'h00000099;
        req_t = 4'b0001;
        for (int c = 0; c < 60 && !got; c++) begin
            step();
            if (ack_t != 4'b0) begin
                got = 1'b1;
                req_t = 4'b0;
            end else if (we_t && addr_t == 32'hC) writes++;
            else if (!we_t && addr_t == 32'h4 && busy_t) polls++;
        end
        nvec++;
        if ({ack_t, tmo_t} !== {4'b0001, 1'b1}) begin
            nerr++; $display("FAIL timeout_drop: got %b expected %b", {ack_t, tmo_t}, {4'b0001, 1'b1});
        end
        nvec++;
        if (polls != 8 || writes != 0) begin
            nerr++; $display("FAIL timeout_polls: got %0d polls %0d writes expected 8 polls 0 writes", polls, writes);
        end
        step();
        nvec++;
        if ({ack_t, tmo_t, busy_t} !== 6'b0) begin
            nerr++; $display("FAIL timeout_single_pulse: got %b expected %b", {ack_t, tmo_t, busy_t}, 6'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rotation();
        test_single();
        test_back_to_back();
        test_rst_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
